dct_block_scheduler: RTL and testbench

Sequencer that walks the captured 224x224 luma frame buffer in 8x8 blocks, fetches each block one pixel per cycle from the single-port image RAM, packs it into a 512-bit MCU word and hands it to the DCT/quantization stage over a valid/ready handshake. It sits between the capture buffer and `dct_quantization`, and replaces the fixed block-0 wiring with a full raster-order pass triggered by the HPS.

---
 rtl/dct_block_scheduler.sv | 145 ++++++++++++++
 tb/tb_dct_block_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_scheduler.sv
// Raster-order 8x8 block fetcher: reads each block from the image RAM and presents it as one MCU word.
// Optional build macro SCHED_STALL_CNT_EN adds a saturating stall_cycles counter output.
module dct_block_scheduler #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H),
    parameter int BW    = $clog2((IMG_W/8)*(IMG_H/8))
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [PIX_W-1:0]      mem_rd_data,
    output logic                  mcu_valid,
    input  logic                  mcu_ready,
    output logic [64*PIX_W-1:0]   mcu_data,
    output logic [BW-1:0]         mcu_index,
    output logic                  mcu_last
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    // state   | meaning
    // IDLE    | waiting for start, outputs low
    // FETCH   | k=0..64: read 64 pixels, load each one cycle later
    // PRESENT | MCU word valid, held until mcu_ready
    // DONE    | one-cycle done pulse

    localparam int NBX = IMG_W / 8;
    localparam int NBY = IMG_H / 8;
    localparam int XW  = (NBX > 1) ? $clog2(NBX) : 1;
    localparam int YW  = (NBY > 1) ? $clog2(NBY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [6:0]           k;
    logic [5:0]           ld_idx;
    logic [XW-1:0]        bx;
    logic [YW-1:0]        by;
    logic [BW-1:0]        blk;
    logic [64*PIX_W-1:0]  mcu_buf;
    logic [AW-1:0]        row, col;
    logic                 last_blk, fetch_end;

    assign last_blk  = (bx == XW'(NBX-1)) && (by == YW'(NBY-1));
    assign fetch_end = (k == 7'd64);
    assign ld_idx    = 6'(k - 7'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   if (fetch_end) state_nxt = S_PRESENT;
            S_PRESENT: if (mcu_ready) state_nxt = last_blk ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mcu_valid = 1'b0;
        case (state)
            S_FETCH: begin
                busy      = 1'b1;
                mem_rd_en = ~k[6];
            end
            S_PRESENT: begin
                busy      = 1'b1;
                mcu_valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Pixel row/column inside the frame; both stay below the image size by construction.
    assign row         = AW'({by, 3'b000}) + AW'(k[5:3]);
    assign col         = AW'({bx, 3'b000}) + AW'(k[2:0]);
    assign mem_rd_addr = mem_rd_en ? (row * AW'(IMG_W) + col) : '0;
    assign mcu_data    = mcu_buf;
    assign mcu_index   = mcu_valid ? blk : '0;
    assign mcu_last    = mcu_valid && last_blk;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k       <= '0;
            bx      <= '0;
            by      <= '0;
            blk     <= '0;
            mcu_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    k   <= '0;
                    bx  <= '0;
                    by  <= '0;
                    blk <= '0;
                end
                S_FETCH: begin
                    if (k != 7'd0) mcu_buf[ld_idx*PIX_W +: PIX_W] <= mem_rd_data;
                    k <= fetch_end ? 7'd0 : k + 7'd1;
                end
                S_PRESENT: begin
                    if (mcu_ready && !last_blk) begin
                        blk <= blk + BW'(1);
                        if (bx == XW'(NBX-1)) begin
                            bx <= '0;
                            by <= by + YW'(1);
                        end else begin
                            bx <= bx + XW'(1);
                        end
                    end
                end
                S_DONE:  mcu_buf <= '0;
                default: ;
            endcase
        end
    end

`ifdef SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (state == S_IDLE && start)
            stall_cycles <= '0;
        else if (mcu_valid && !mcu_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: RAM model plus a block-level reference computed from frame coordinates.
module tb_dct_block_scheduler;
    localparam int IMG_W = 224;
    localparam int IMG_H = 224;
    localparam int PIX_W = 8;
    localparam int AW    = 16;
    localparam int BW    = 10;
    localparam int NBX   = IMG_W / 8;
    localparam int NBLK  = (IMG_W / 8) * (IMG_H / 8);
    localparam int NPIX  = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              reset_n, start, busy, done, mem_rd_en, mcu_valid, mcu_ready, mcu_last;
    logic [AW-1:0]     mem_rd_addr;
    logic [PIX_W-1:0]  mem_rd_data;
    logic [511:0]      mcu_data;
    logic [BW-1:0]     mcu_index;
`ifdef SCHED_STALL_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    int vectors = 0, miscompares = 0, done_cnt = 0;
    int pat_mul = 1, pat_xor = 0;
    int first_addr_last, last_addr_last;

    always #5 clk = ~clk;

    dct_block_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .AW(AW), .BW(BW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_data(mcu_data),
        .mcu_index(mcu_index), .mcu_last(mcu_last)
`ifdef SCHED_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [7:0] pix(input int a);
        int v;
        v = (a * pat_mul) ^ pat_xor;
        return v[7:0];
    endfunction

    // Single-port RAM: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? pix(int'(mem_rd_addr)) : 8'($urandom);
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one pass from start; returns early after nblk handshakes when nblk < NBLK.
    // mode 0: ready high, 1: ready ~30% random, 2: ready low 10 cycles on blocks 2, 5 and 9.
    task automatic drive_pass(input int mode, input int nblk, input bit repulse,
                              output int done_cyc, output int stalls);
        int c = 0, blk = 0, rd_cnt = 0, last_hs = 0, stall_left = 0;
        int bx, by, ea;
        bit new_blk = 1'b1, fin = 1'b0;
        logic [511:0] exp_data = '0;
        done_cyc = -1;
        stalls   = 0;
        start     = 1'b1;
        mcu_ready = 1'b1;
        step;
        c = 1;
        while (!fin && c < 60000) begin
            start = repulse && (c == 100);
`ifdef SCHED_STALL_CNT_EN
            if (c == 1) begin
                vectors++;
                if (stall_cycles !== 32'd0) begin
                    miscompares++;
                    $display("FAIL stall_clear_on_start: got %0d want 0", stall_cycles);
                end
            end
`endif
            bx = blk % NBX;
            by = blk / NBX;
            if (!done) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_high cycle %0d: got %b want 1", c, busy);
                end
            end
            if (mem_rd_en) begin
                ea = (by*8 + rd_cnt/8) * IMG_W + bx*8 + rd_cnt%8;
                vectors++;
                if (mcu_valid || int'(mem_rd_addr) != ea || int'(mem_rd_addr) >= NPIX) begin
                    miscompares++;
                    $display("FAIL read_addr blk %0d pix %0d: got %0d (valid=%b) want %0d",
                             blk, rd_cnt, mem_rd_addr, mcu_valid, ea);
                end
                if (blk == NBLK-1) begin
                    if (rd_cnt == 0) first_addr_last = int'(mem_rd_addr);
                    last_addr_last = int'(mem_rd_addr);
                end
                rd_cnt++;
            end
            mcu_ready = (mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (mcu_valid) begin
                if (new_blk) begin
                    new_blk = 1'b0;
                    vectors++;
                    if (c != last_hs + 66 || rd_cnt != 64) begin
                        miscompares++;
                        $display("FAIL valid_timing blk %0d: got cycle %0d reads %0d want cycle %0d reads 64",
                                 blk, c, rd_cnt, last_hs + 66);
                    end
                    for (int r = 0; r < 8; r++)
                        for (int cc = 0; cc < 8; cc++)
                            exp_data[(r*8+cc)*8 +: 8] = pix((by*8 + r) * IMG_W + bx*8 + cc);
                    if (mode == 2 && (blk == 2 || blk == 5 || blk == 9)) stall_left = 10;
                end
                if (stall_left > 0) begin
                    mcu_ready = 1'b0;
                    stall_left--;
                end
                vectors++;
                if (mcu_data !== exp_data || mcu_index !== BW'(blk) || mcu_last !== (blk == NBLK-1)) begin
                    miscompares++;
                    $display("FAIL mcu_word cycle %0d: got idx %0d last %b data %h want idx %0d last %b data %h",
                             c, mcu_index, mcu_last, mcu_data[63:0], blk, (blk == NBLK-1), exp_data[63:0]);
                end
                if (!mcu_ready) begin
                    stalls++;
                end else begin
                    last_hs = c;
                    blk++;
                    rd_cnt  = 0;
                    new_blk = 1'b1;
                    if (blk == nblk && nblk < NBLK) return;
                end
            end
            if (done) begin
                vectors++;
                if (c != last_hs + 1 || blk != NBLK || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_pulse: got cycle %0d blocks %0d busy %b want cycle %0d blocks %0d busy 0",
                             c, blk, busy, last_hs + 1, NBLK);
                end
                done_cyc = c;
                fin = 1'b1;
            end
            if (!fin) begin
                step;
                c++;
            end
        end
        if (!fin) begin
            vectors++;
            miscompares++;
            $display("FAIL pass_timeout: got no done by cycle %0d want done", c);
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        start     = 1'b0;
        mcu_ready = 1'b0;
        repeat (3) step;
        vectors++;
        if ({busy, done, mem_rd_en, mcu_valid, mcu_last} !== 5'b0 || mem_rd_addr !== '0 ||
            mcu_data !== '0 || mcu_index !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy %b done %b rd %b valid %b addr %0d idx %0d want all 0",
                     busy, done, mem_rd_en, mcu_valid, mem_rd_addr, mcu_index);
        end
        reset_n   = 1'b1;
        mcu_ready = 1'b1;
        repeat (3) step;
        vectors++;
        if ({busy, done, mem_rd_en, mcu_valid} !== 4'b0 || mcu_data !== '0) begin
            miscompares++;
            $display("FAIL idle_with_ready: got busy %b done %b rd %b valid %b want all 0",
                     busy, done, mem_rd_en, mcu_valid);
        end
    endtask

    task automatic test_full_pass;
        int dc, st, d0, exp_done;
        pat_mul = 1;
        pat_xor = 0;
        d0 = done_cnt;
`ifdef SCHED_STALL_CNT_EN
        drive_pass(2, NBLK, 1'b1, dc, st);
        exp_done = NBLK * 66 + 1 + 30;
`else
        drive_pass(0, NBLK, 1'b1, dc, st);
        exp_done = NBLK * 66 + 1;
`endif
        vectors++;
        if (dc != exp_done) begin
            miscompares++;
            $display("FAIL full_pass_done_cycle: got %0d want %0d", dc, exp_done);
        end
        vectors++;
        if (first_addr_last != 216*224 + 216 || last_addr_last != 223*224 + 223) begin
            miscompares++;
            $display("FAIL last_block_addr: got first %0d last %0d want first %0d last %0d",
                     first_addr_last, last_addr_last, 216*224 + 216, 223*224 + 223);
        end
        start = 1'b0;
        repeat (5) step;
        vectors++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || mcu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got %0d pulses busy %b want 1 pulse busy 0", done_cnt - d0, busy);
        end
`ifdef SCHED_STALL_CNT_EN
        vectors++;
        if (stall_cycles !== 32'd30 || st != 30) begin
            miscompares++;
            $display("FAIL stall_count_after_done: got %0d (model %0d) want 30", stall_cycles, st);
        end
`endif
    endtask

    task automatic test_random_ready;
        int dc, st, d0;
        pat_mul = int'($urandom) | 1;
        pat_xor = int'($urandom_range(0, 255));
        d0 = done_cnt;
        drive_pass(1, 40, 1'b0, dc, st);
`ifdef SCHED_STALL_CNT_EN
        vectors++;
        if (stall_cycles !== 32'(st)) begin
            miscompares++;
            $display("FAIL stall_count_random: got %0d want %0d", stall_cycles, st);
        end
`endif
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        step;
        vectors++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL random_abort: got %0d done pulses busy %b want 0 pulses busy 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_pass;
        int dc, st, d0;
        pat_mul = 1;
        pat_xor = 0;
        d0 = done_cnt;
        start     = 1'b1;
        mcu_ready = 1'b1;
        step;
        start = 1'b0;
        repeat (5*66 + 19) step;
        vectors++;
        if (mem_rd_en !== 1'b1 || int'(mem_rd_addr) != 5*8 + 2*IMG_W + 3) begin
            miscompares++;
            $display("FAIL mid_fetch_read: got rd %b addr %0d want rd 1 addr %0d",
                     mem_rd_en, mem_rd_addr, 5*8 + 2*IMG_W + 3);
        end
        reset_n = 1'b0;
        step;
        vectors++;
        if ({busy, done, mem_rd_en, mcu_valid, mcu_last} !== 5'b0 || mem_rd_addr !== '0 ||
            mcu_data !== '0 || mcu_index !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got busy %b rd %b valid %b addr %0d want all 0",
                     busy, mem_rd_en, mcu_valid, mem_rd_addr);
        end
        reset_n = 1'b1;
        repeat (4) step;
        vectors++;
        if (done_cnt != d0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got %0d pulses busy %b want 0 pulses busy 0", done_cnt - d0, busy);
        end
        drive_pass(0, 1, 1'b0, dc, st);
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        step;
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_random_ready();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
